// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader: fills the instruction RAM from a framed byte stream and
// holds the core in reset until a frame with a good checksum is loaded.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wd,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] words_loaded
);

  localparam logic [31:0] c_depth = 32'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_word;
  logic [7:0]  r_csum;

  logic        w_accept;
  logic [15:0] w_len;
  logic        w_len_ok;
  logic        w_last;

  assign w_accept = rx_valid && rx_ready;
  assign w_len    = {rx_data, r_len_lo};
  assign w_len_ok = (w_len != 16'd0) && ({16'd0, w_len} <= c_depth);
  // words_loaded equals the index of the word currently in WRITE
  assign w_last   = (32'(words_loaded) + 32'd1) == {16'd0, r_len};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_len_lo     <= 8'd0;
      r_len        <= 16'd0;
      r_byte_idx   <= 2'd0;
      r_word       <= 24'd0;
      r_csum       <= 8'd0;
      rx_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wd       <= 32'd0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state      <= S_LEN_LO;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            r_csum       <= 8'd0;
            r_byte_idx   <= 2'd0;
            rx_ready     <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len_lo <= rx_data;
            r_state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len_ok) begin
              r_state <= S_DATA;
            end else begin
              r_state  <= S_ERR;
              error    <= 1'b1;
              rx_ready <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_csum     <= r_csum ^ rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_word[7:0]   <= rx_data;
              2'd1: r_word[15:8]  <= rx_data;
              2'd2: r_word[23:16] <= rx_data;
              default: begin
                r_state  <= S_WRITE;
                rx_ready <= 1'b0;
                mem_we   <= 1'b1;
                mem_addr <= BASE_ADDR + (32'(words_loaded) << 2);
                mem_wd   <= {rx_data, r_word};
              end
            endcase
          end
        end
        S_WRITE: begin
          mem_we       <= 1'b0;
          rx_ready     <= 1'b1;
          words_loaded <= words_loaded + CW'(1);
          r_state      <= w_last ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          if (w_accept) begin
            rx_ready <= 1'b0;
            if (rx_data == r_csum) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              r_state <= S_ERR;
              error   <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader: directed checks of the instruction-memory loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int n_asrt = 0;
  int n_fail = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  fr[$];

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wd);
      n_asrt++;
      assert (rx_ready === 1'b0) else begin
        n_fail++;
        $error("FAIL rx_ready_in_write observed=%b expected=0", rx_ready);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("byte_accept_timeout", 32'(n < 100), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  // sends the queued frame; start is pulsed again before byte start_at
  task automatic send_frame(input int gapmax, input int start_at);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == start_at) pulse_start();
      send_byte(fr[i], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
    end
    tick();
  endtask

  task automatic check_good_pair(input string tag);
    chk({tag, "_nwr"},  32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk({tag, "_a0"}, wa[0], 32'h0);
      chk({tag, "_d0"}, wd[0], 32'h12345678);
      chk({tag, "_a1"}, wa[1], 32'h4);
      chk({tag, "_d1"}, wd[1], 32'hDEADBEEF);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"},  32'(error), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_wl"},   32'(words_loaded), 32'd2);
  endtask

  initial begin
    logic [7:0]  cs;
    logic [31:0] w;

    // reset state
    repeat (3) tick();
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_hold",  32'(cpu_hold), 32'd0);
    chk("rst_flags", {30'd0, done, error}, 32'd0);
    chk("rst_wl",    32'(words_loaded), 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_wd",    mem_wd, 32'd0);
    reset = 1'b1;
    tick();

    // good load
    wa = {}; wd = {};
    fr = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    pulse_start();
    chk("good_hold_busy",  32'(cpu_hold), 32'd1);
    chk("good_ready_busy", 32'(rx_ready), 32'd1);
    send_frame(0, -1);
    check_good_pair("good");

    // bad checksum
    wa = {}; wd = {};
    fr[10] = 8'h2B;
    pulse_start();
    send_frame(0, -1);
    chk("badcs_nwr",  32'(wa.size()), 32'd2);
    chk("badcs_err",  32'(error), 32'd1);
    chk("badcs_done", 32'(done), 32'd0);
    chk("badcs_hold", 32'(cpu_hold), 32'd1);

    // zero length
    wa = {}; wd = {};
    fr = {8'h00, 8'h00};
    pulse_start();
    send_frame(0, -1);
    repeat (3) tick();
    chk("len0_err",   32'(error), 32'd1);
    chk("len0_nwr",   32'(wa.size()), 32'd0);
    chk("len0_ready", 32'(rx_ready), 32'd0);

    // length 257
    fr = {8'h01, 8'h01};
    pulse_start();
    send_frame(0, -1);
    repeat (3) tick();
    chk("len257_err",  32'(error), 32'd1);
    chk("len257_nwr",  32'(wa.size()), 32'd0);
    chk("len257_hold", 32'(cpu_hold), 32'd1);

    // good frame with random rx_valid gaps
    wa = {}; wd = {};
    fr = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    pulse_start();
    send_frame(5, -1);
    check_good_pair("gaps");

    // asynchronous reset mid-load
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(fr[i], 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ready", 32'(rx_ready), 32'd0);
    chk("arst_hold",  32'(cpu_hold), 32'd0);
    chk("arst_flags", {30'd0, done, error}, 32'd0);
    chk("arst_wl",    32'(words_loaded), 32'd0);
    chk("arst_addr",  mem_addr, 32'd0);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("arst_idle_ready", 32'(rx_ready), 32'd0);
    wa = {}; wd = {};
    pulse_start();
    send_frame(0, -1);
    check_good_pair("after_rst");

    // full depth, with a stray start mid-load
    wa = {}; wd = {};
    fr = {8'h00, 8'h01};
    cs = 8'h00;
    for (int k = 0; k < 256; k++) begin
      w = (32'(k) * 32'h01030507) ^ 32'hA55A0FF0;
      for (int b = 0; b < 4; b++) begin
        fr.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
    fr.push_back(cs);
    pulse_start();
    send_frame(0, 402);
    chk("full_nwr",  32'(wa.size()), 32'd256);
    chk("full_done", 32'(done), 32'd1);
    chk("full_err",  32'(error), 32'd0);
    chk("full_wl",   32'(words_loaded), 32'd256);
    if (wa.size() == 256) begin
      chk("full_last_addr", wa[255], 32'h3FC);
      for (int k = 0; k < 256; k++) begin
        w = (32'(k) * 32'h01030507) ^ 32'hA55A0FF0;
        chk("full_addr", wa[k], 32'(k) * 32'd4);
        chk("full_data", wd[k], w);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
